realloc_copy_engine: RTL and testbench
======================================

Name: realloc_copy_engine

Overview:
- Block-copy engine directly downstream of the memory manager's allocator.
- Consumes the allocator's realloc copy command (src_addr, dst_addr, copy_len, copy_active) and moves the old block's payload to the newly allocated block.
- Copies in read-burst / write-burst pairs through a local word buffer, then returns copy_done to the allocator.
- Owns its own read/write master port toward the memory arbiter.

Parameters:
- BURST_WORDS, 16, maximum words per burst and depth of the local buffer (1..16, limited by the 4-bit len fields).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- copy_active  in  1  copy command level from the allocator; a copy starts on its rising edge
- src_addr  in  32  source byte address; bits[1:0] ignored
- dst_addr  in  32  destination byte address; bits[1:0] ignored
- copy_len  in  32  length in bytes; rounded up to whole words
- copy_done  out  1  one-cycle pulse when the copy is complete
- busy  out  1  high from the accepted start until the copy_done cycle, inclusive
- read_request  out  1  read burst request, held until its first beat
- read_address  out  32  word-aligned burst start address
- read_len  out  4  beats minus 1
- read_valid  in  1  one read beat delivered this cycle
- read_data  in  32  read beat data
- write_request  out  1  write burst request, held through its last beat
- write_address  out  32  word-aligned burst start address
- write_len  out  4  beats minus 1
- write_data  out  32  current write beat
- write_valid  in  1  current write beat accepted this cycle

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0. Buffer contents don't-care. Edge-detect register cleared. Reset mid-copy aborts with no copy_done.
- Start condition:
  - Start = copy_active high while the previous-cycle sample was low and state=IDLE.
  - On start, latch rd_ptr=src_addr&~3, wr_ptr=dst_addr&~3, words=(copy_len+3)>>2, with 32-bit arithmetic (carry dropped).
  - A rising edge outside IDLE is ignored.
  - copy_active falling mid-copy is ignored; the copy runs to completion.
- Burst size: n = min(words_left, BURST_WORDS).
- States:
  - IDLE: wait for start. If words=0, go to DONE next cycle. Otherwise go to READ.
  - READ:
    - Drive read_request=1, read_address=rd_ptr, read_len=n-1.
    - Hold request, address and len stable until the first read_valid.
    - read_request drops in the cycle after the first beat.
    - Each read_valid writes read_data into buf[beat] and increments beat.
    - After beat n-1 is captured, go to WRITE with beat=0 and rd_ptr+=4n.
    - read_valid while not in READ is ignored.
  - WRITE:
    - Drive write_request=1, write_address=wr_ptr, write_len=n-1, write_data=buf[beat].
    - write_data must be valid in the same cycle write_request rises.
    - Each write_valid advances beat.
    - On the cycle of the last accepted beat, write_request stays 1. It drops the following cycle.
    - Then words_left-=n and wr_ptr+=4n. If words_left=0 go to DONE, otherwise go to READ.
  - DONE: copy_done=1 for exactly one cycle, busy=1 in the same cycle. Next state is IDLE.
- Ordering and overlap:
  - Copy order is ascending addresses.
  - Overlapping regions are correct only when dst<=src or the regions are disjoint; dst>src with overlap is unsupported.
- Address wrap: pointer increments wrap modulo 2^32 with no error.
- Throughput: at most one beat per cycle. No bubble is required between a burst's last write beat and the next read request beyond the single state-transition cycle.
- Restart: back-to-back copies need copy_active to deassert for at least one cycle between commands.

Test Plan:
- Single-word copy: src=0x70000010, dst=0x70000100, len=4 -> one read (addr 0x70000010, len 0), one write (addr 0x70000100, len 0, data = beat read); copy_done pulses once, 1 cycle after the last write_valid.
- Multi-burst copy: len=100 bytes (25 words), BURST_WORDS=16 -> read len 15 @src, write len 15 @dst, then read len 8 @src+64, write len 8 @dst+64; data matches word for word; one copy_done.
- Rounding and alignment: src=0x70000003, len=5 -> address 0x70000000, 2 words (len 1).
- Zero length: len=0 -> no read_request or write_request; copy_done exactly 2 cycles after the copy_active rise.
- Stalls: random read_valid/write_valid gaps; early deassertion of copy_active; a second rising edge while busy -> request fields stay stable and the second edge is ignored; copy completes correctly.
- Reset mid-copy: assert rst=0 during the WRITE of burst 2 -> all outputs 0 asynchronously and no copy_done; a new command after reset completes normally.

Source files
------------

// File: rtl/realloc_copy_engine.sv
// Realloc copy engine: moves a block from the old allocation to the new one
// in read-burst / write-burst pairs staged through a small local word buffer,
// then pulses copy_done back to the allocator.
module realloc_copy_engine #(
    parameter int BURST_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        copy_active,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [31:0] copy_len,
    output logic        copy_done,
    output logic        busy,
    output logic        read_request,
    output logic [31:0] read_address,
    output logic [3:0]  read_len,
    input  logic        read_valid,
    input  logic [31:0] read_data,
    output logic        write_request,
    output logic [31:0] write_address,
    output logic [3:0]  write_len,
    output logic [31:0] write_data,
    input  logic        write_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0] BURST_MAX  = 32'(BURST_WORDS);
    localparam logic [3:0]  BURST_LAST = 4'(BURST_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic        act_q, act_d;
    logic        act_prev_q, act_prev_d;
    logic [31:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] left_q, left_d;
    logic [3:0]  beat_q, beat_d;

    logic [31:0] buf_mem [BURST_WORDS];

    logic        start;
    logic [31:0] cmd_words;
    logic [31:0] burst_n;
    logic [3:0]  burst_last;
    logic [31:0] burst_bytes;

    // Burst sizing and start detection on the registered copy_active samples
    always_comb begin
        start       = act_q && !act_prev_q && (state_q == ST_IDLE);
        cmd_words   = (copy_len + 32'd3) >> 2;
        burst_n     = (left_q < BURST_MAX) ? left_q : BURST_MAX;
        // left_q is below BURST_MAX in the first branch, so its low nibble holds it
        burst_last  = (left_q < BURST_MAX) ? 4'(left_q[3:0] - 4'd1) : BURST_LAST;
        burst_bytes = burst_n << 2;
    end

    // Next-state logic: walk IDLE -> (READ -> WRITE)* -> DONE -> IDLE
    always_comb begin
        state_d    = state_q;
        act_d      = copy_active;
        act_prev_d = act_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        left_d     = left_q;
        beat_d     = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rd_ptr_d = src_addr & ~32'd3;
                    wr_ptr_d = dst_addr & ~32'd3;
                    left_d   = cmd_words;
                    beat_d   = 4'd0;
                    state_d  = (cmd_words == 32'd0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (read_valid) begin
                    if (beat_q == burst_last) begin
                        beat_d   = 4'd0;
                        rd_ptr_d = rd_ptr_q + burst_bytes;
                        state_d  = ST_WRITE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (write_valid) begin
                    if (beat_q == burst_last) begin
                        beat_d   = 4'd0;
                        wr_ptr_d = wr_ptr_q + burst_bytes;
                        left_d   = left_q - burst_n;
                        state_d  = (left_q == burst_n) ? ST_DONE : ST_READ;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and pointer registers; reset aborts any copy in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            act_q      <= 1'b0;
            act_prev_q <= 1'b0;
            rd_ptr_q   <= 32'd0;
            wr_ptr_q   <= 32'd0;
            left_q     <= 32'd0;
            beat_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            act_prev_q <= act_prev_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            left_q     <= left_d;
            beat_q     <= beat_d;
        end
    end

    // Staging buffer: each read beat lands at its beat index
    always_ff @(posedge clk) begin
        if (state_q == ST_READ && read_valid) begin
            buf_mem[beat_q] <= read_data;
        end
    end

    // Outputs decode from state only, so they are all zero while in reset
    always_comb begin
        read_request  = 1'b0;
        read_address  = 32'd0;
        read_len      = 4'd0;
        write_request = 1'b0;
        write_address = 32'd0;
        write_len     = 4'd0;
        write_data    = 32'd0;
        copy_done     = (state_q == ST_DONE);
        busy          = (state_q != ST_IDLE);
        case (state_q)
            ST_READ: begin
                // Request is held until the first beat lands, then released
                read_request = (beat_q == 4'd0);
                read_address = rd_ptr_q;
                read_len     = burst_last;
            end
            ST_WRITE: begin
                write_request = 1'b1;
                write_address = wr_ptr_q;
                write_len     = burst_last;
                write_data    = buf_mem[beat_q];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_realloc_copy_engine.sv
// Testbench for realloc_copy_engine: randomized memory slaves with stalls,
// a burst-list reference model, and per-scenario checks.
module tb_realloc_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        copy_active = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0, copy_len = '0;
    logic        copy_done, busy;
    logic        read_request;
    logic [31:0] read_address;
    logic [3:0]  read_len;
    logic        read_valid;
    logic [31:0] read_data;
    logic        write_request;
    logic [31:0] write_address;
    logic [3:0]  write_len;
    logic [31:0] write_data;
    logic        write_valid;

    realloc_copy_engine #(.BURST_WORDS(16)) dut (
        .clk(clk), .rst(rst), .copy_active(copy_active),
        .src_addr(src_addr), .dst_addr(dst_addr), .copy_len(copy_len),
        .copy_done(copy_done), .busy(busy),
        .read_request(read_request), .read_address(read_address), .read_len(read_len),
        .read_valid(read_valid), .read_data(read_data),
        .write_request(write_request), .write_address(write_address), .write_len(write_len),
        .write_data(write_data), .write_valid(write_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stall_pct = 0;
    logic [31:0] data_seed = 32'h1234_5678;

    logic [31:0] rd_addr_log[$], rd_len_log[$], wr_addr_log[$], wr_len_log[$], wr_data_log[$];
    logic [31:0] exp_rd_addr[$], exp_rd_len[$], exp_wr_addr[$], exp_wr_len[$], exp_data[$];
    int done_cnt, done_cyc, busy_err, rd_unstable, rd_drop_err, wr_unstable, wr_drop_err;
    int last_wv_cyc, rise_cyc;
    bit rd_busy, wr_busy;
    int rd_n, rd_idx, wr_n, wr_idx;
    logic [31:0] rd_cur_addr, wr_cur_addr;
    logic [3:0]  rd_cur_len, wr_cur_len;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ data_seed;
    endfunction

    function automatic int qdiff(input logic [31:0] a[$], input logic [31:0] b[$]);
        int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
        return d;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Read slave: answers each read burst with memory words, randomly stalled
    initial begin
        read_valid = 1'b0;
        read_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rd_busy = 0;
                read_valid = 1'b0;
            end else begin
                if (read_valid) begin
                    rd_idx++;
                    if (read_request) rd_drop_err++;
                    if (rd_idx == rd_n) rd_busy = 0;
                end
                read_valid = 1'b0;
                if (!rd_busy && read_request) begin
                    rd_busy = 1; rd_idx = 0; rd_n = int'(read_len) + 1;
                    rd_cur_addr = read_address; rd_cur_len = read_len;
                    rd_addr_log.push_back(read_address);
                    rd_len_log.push_back({28'd0, read_len});
                end
                if (rd_busy) begin
                    if (rd_idx == 0 && (!read_request || read_address !== rd_cur_addr || read_len !== rd_cur_len))
                        rd_unstable++;
                    if ($urandom_range(0, 99) >= stall_pct) begin
                        read_valid = 1'b1;
                        read_data  = mem_word(rd_cur_addr + 32'(4 * rd_idx));
                    end
                end
            end
        end
    end

    // Write slave: accepts write beats with random stalls and logs the data
    initial begin
        write_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr_busy = 0;
                write_valid = 1'b0;
            end else begin
                if (write_valid) begin
                    wr_idx++;
                    if (wr_idx == wr_n) begin
                        wr_busy = 0;
                        if (write_request) wr_drop_err++;
                    end
                end
                write_valid = 1'b0;
                if (!wr_busy && write_request) begin
                    wr_busy = 1; wr_idx = 0; wr_n = int'(write_len) + 1;
                    wr_cur_addr = write_address; wr_cur_len = write_len;
                    wr_addr_log.push_back(write_address);
                    wr_len_log.push_back({28'd0, write_len});
                end
                if (wr_busy) begin
                    if (!write_request || write_address !== wr_cur_addr || write_len !== wr_cur_len)
                        wr_unstable++;
                    if ($urandom_range(0, 99) >= stall_pct) begin
                        write_valid = 1'b1;
                        wr_data_log.push_back(write_data);
                        last_wv_cyc = cyc;
                    end
                end
            end
        end
    end

    // copy_done monitor
    initial forever begin
        @(negedge clk);
        if (copy_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy !== 1'b1) busy_err++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        rd_addr_log.delete(); rd_len_log.delete();
        wr_addr_log.delete(); wr_len_log.delete(); wr_data_log.delete();
        done_cnt = 0; done_cyc = -1; busy_err = 0;
        rd_unstable = 0; rd_drop_err = 0; wr_unstable = 0; wr_drop_err = 0;
        last_wv_cyc = -1;
    endtask

    // Reference model: expected burst list and data for a copy command
    task automatic build_expect(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
        logic [31:0] left, rp, wp, n;
        exp_rd_addr.delete(); exp_rd_len.delete();
        exp_wr_addr.delete(); exp_wr_len.delete(); exp_data.delete();
        left = (len + 32'd3) >> 2;
        rp = src & ~32'd3;
        wp = dst & ~32'd3;
        while (left != 0) begin
            n = (left > 16) ? 32'd16 : left;
            exp_rd_addr.push_back(rp); exp_rd_len.push_back(n - 1);
            exp_wr_addr.push_back(wp); exp_wr_len.push_back(n - 1);
            for (int i = 0; i < int'(n); i++) exp_data.push_back(mem_word(rp + 32'(4 * i)));
            rp += 4 * n;
            wp += 4 * n;
            left -= n;
        end
    endtask

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
        clear_logs();
        build_expect(src, dst, len);
        src_addr = src; dst_addr = dst; copy_len = len;
        copy_active = 1'b1;
        rise_cyc = cyc;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin
            tick();
            t++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: copy_done seen %0d times, required 1 within 3000 cycles", name, done_cnt);
        end
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        checks++;
        if ({read_request, write_request, copy_done, busy, read_address, read_len,
             write_address, write_len, write_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rreq=%b wreq=%b done=%b busy=%b, required all zero",
                     read_request, write_request, copy_done, busy);
        end
        rst = 1'b1;
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        stall_pct = 0;
        data_seed = $urandom;
        start_copy(32'h7000_0010, 32'h7000_0100, 32'd4);
        wait_done("single");
        copy_active = 1'b0;
        checks++;
        if (rd_addr_log.size() != 1 || rd_addr_log[0] !== 32'h7000_0010 || rd_len_log[0] !== 32'd0) begin
            errors++;
            $display("FAIL single_read: bursts=%0d addr=%h len=%0d, required 1 @70000010 len 0",
                     rd_addr_log.size(), rd_addr_log.size() ? rd_addr_log[0] : 32'hx, rd_len_log.size() ? rd_len_log[0] : 32'hx);
        end
        checks++;
        if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 32'h7000_0100 || wr_len_log[0] !== 32'd0) begin
            errors++;
            $display("FAIL single_write: bursts=%0d, required 1 @70000100 len 0", wr_addr_log.size());
        end
        checks++;
        if (wr_data_log.size() != 1 || wr_data_log[0] !== mem_word(32'h7000_0010)) begin
            errors++;
            $display("FAIL single_data: got %0d words, first=%h, required %h",
                     wr_data_log.size(), wr_data_log.size() ? wr_data_log[0] : 32'hx, mem_word(32'h7000_0010));
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_wv_cyc + 1) begin
            errors++;
            $display("FAIL single_done_timing: pulses=%0d at cycle %0d, required 1 at cycle %0d",
                     done_cnt, done_cyc, last_wv_cyc + 1);
        end
        tick(2);
        $display("test_single_word: src=70000010 dst=70000100 len=4 done_cnt=%0d", done_cnt);
    endtask

    task automatic test_multi_burst();
        stall_pct = 0;
        data_seed = $urandom;
        start_copy(32'h7000_1000, 32'h7000_8000, 32'd100);
        wait_done("multi");
        copy_active = 1'b0;
        checks++;
        if (rd_addr_log.size() != 2 || rd_addr_log[0] !== 32'h7000_1000 || rd_len_log[0] !== 32'd15 ||
            rd_addr_log[1] !== 32'h7000_1040 || rd_len_log[1] !== 32'd8) begin
            errors++;
            $display("FAIL multi_read_bursts: got %0d bursts, required 2 (len 15 @70001000, len 8 @70001040)",
                     rd_addr_log.size());
        end
        checks++;
        if (wr_addr_log.size() != 2 || wr_addr_log[0] !== 32'h7000_8000 || wr_len_log[0] !== 32'd15 ||
            wr_addr_log[1] !== 32'h7000_8040 || wr_len_log[1] !== 32'd8) begin
            errors++;
            $display("FAIL multi_write_bursts: got %0d bursts, required 2 (len 15 @70008000, len 8 @70008040)",
                     wr_addr_log.size());
        end
        checks++;
        if (qdiff(wr_data_log, exp_data) != 0) begin
            errors++;
            $display("FAIL multi_data: %0d word differences over %0d words, required 0",
                     qdiff(wr_data_log, exp_data), exp_data.size());
        end
        checks++;
        if (done_cnt != 1 || (busy_err + rd_unstable + rd_drop_err + wr_unstable + wr_drop_err) != 0) begin
            errors++;
            $display("FAIL multi_protocol: done=%0d busy_err=%0d rd_unst=%0d rd_drop=%0d wr_unst=%0d wr_drop=%0d, required done=1 rest 0",
                     done_cnt, busy_err, rd_unstable, rd_drop_err, wr_unstable, wr_drop_err);
        end
        tick(2);
        $display("test_multi_burst: len=100 bursts rd=%0d wr=%0d words=%0d", rd_addr_log.size(), wr_addr_log.size(), wr_data_log.size());
    endtask

    task automatic test_rounding();
        stall_pct = 10;
        data_seed = $urandom;
        start_copy(32'h7000_0003, 32'h7000_0202, 32'd5);
        wait_done("round");
        copy_active = 1'b0;
        checks++;
        if (rd_addr_log.size() != 1 || rd_addr_log[0] !== 32'h7000_0000 || rd_len_log[0] !== 32'd1) begin
            errors++;
            $display("FAIL round_read: bursts=%0d addr=%h, required 1 @70000000 len 1",
                     rd_addr_log.size(), rd_addr_log.size() ? rd_addr_log[0] : 32'hx);
        end
        checks++;
        if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 32'h7000_0200 || wr_len_log[0] !== 32'd1 ||
            qdiff(wr_data_log, exp_data) != 0) begin
            errors++;
            $display("FAIL round_write: bursts=%0d words=%0d, required 1 @70000200 len 1 with matching data",
                     wr_addr_log.size(), wr_data_log.size());
        end
        tick(2);
        $display("test_rounding: src=70000003 len=5 words=%0d", wr_data_log.size());
    endtask

    task automatic test_zero_len();
        stall_pct = 0;
        start_copy(32'h7000_0040, 32'h7000_0400, 32'd0);
        wait_done("zero");
        copy_active = 1'b0;
        checks++;
        if (done_cnt != 1 || done_cyc != rise_cyc + 2) begin
            errors++;
            $display("FAIL zero_done_timing: pulses=%0d at cycle %0d, required 1 at cycle %0d",
                     done_cnt, done_cyc, rise_cyc + 2);
        end
        checks++;
        if (rd_addr_log.size() != 0 || wr_addr_log.size() != 0) begin
            errors++;
            $display("FAIL zero_no_bursts: read bursts=%0d write bursts=%0d, required 0",
                     rd_addr_log.size(), wr_addr_log.size());
        end
        tick(2);
        $display("test_zero_len: done at +%0d cycles", done_cyc - rise_cyc);
    endtask

    task automatic test_stall_restart();
        int t = 0;
        stall_pct = 50;
        data_seed = $urandom;
        start_copy(32'h7100_0000, 32'h7000_0000, 32'd150);
        while (rd_addr_log.size() == 0 && t < 200) begin
            tick();
            t++;
        end
        copy_active = 1'b0;
        tick(2);
        copy_active = 1'b1;
        wait_done("stall");
        checks++;
        if (qdiff(rd_addr_log, exp_rd_addr) + qdiff(rd_len_log, exp_rd_len) +
            qdiff(wr_addr_log, exp_wr_addr) + qdiff(wr_len_log, exp_wr_len) != 0) begin
            errors++;
            $display("FAIL stall_bursts: rd=%0d wr=%0d bursts, required %0d each with model addresses",
                     rd_addr_log.size(), wr_addr_log.size(), exp_rd_addr.size());
        end
        checks++;
        if (qdiff(wr_data_log, exp_data) != 0) begin
            errors++;
            $display("FAIL stall_data: %0d differences, required 0", qdiff(wr_data_log, exp_data));
        end
        checks++;
        if ((busy_err + rd_unstable + rd_drop_err + wr_unstable + wr_drop_err) != 0) begin
            errors++;
            $display("FAIL stall_protocol: busy_err=%0d rd_unst=%0d rd_drop=%0d wr_unst=%0d wr_drop=%0d, required 0",
                     busy_err, rd_unstable, rd_drop_err, wr_unstable, wr_drop_err);
        end
        tick(6);
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_second_edge: done pulses=%0d busy=%b, required 1 and 0", done_cnt, busy);
        end
        copy_active = 1'b0;
        tick(2);
        $display("test_stall_restart: len=150 words=%0d done_cnt=%0d", wr_data_log.size(), done_cnt);
    endtask

    task automatic test_wrap();
        stall_pct = 20;
        data_seed = $urandom;
        start_copy(32'hFFFF_FFE0, 32'h0000_1000, 32'd80);
        wait_done("wrap");
        copy_active = 1'b0;
        checks++;
        if (rd_addr_log.size() != 2 || rd_addr_log[1] !== 32'h0000_0020 || rd_len_log[1] !== 32'd3) begin
            errors++;
            $display("FAIL wrap_read: bursts=%0d second addr=%h, required 2 with second @00000020 len 3",
                     rd_addr_log.size(), rd_addr_log.size() > 1 ? rd_addr_log[1] : 32'hx);
        end
        checks++;
        if (qdiff(wr_data_log, exp_data) + qdiff(wr_addr_log, exp_wr_addr) != 0) begin
            errors++;
            $display("FAIL wrap_data: %0d differences, required 0",
                     qdiff(wr_data_log, exp_data) + qdiff(wr_addr_log, exp_wr_addr));
        end
        tick(2);
        $display("test_wrap: src=FFFFFFE0 len=80 words=%0d", wr_data_log.size());
    endtask

    task automatic test_reset_mid();
        int t = 0;
        stall_pct = 20;
        data_seed = $urandom;
        start_copy(32'h7200_0000, 32'h7300_0000, 32'd160);
        while (!(wr_addr_log.size() == 2 && wr_busy) && t < 2000) begin
            tick();
            t++;
        end
        checks++;
        if (wr_addr_log.size() != 2) begin
            errors++;
            $display("FAIL rstmid_reach_burst2: write bursts=%0d, required 2 before reset", wr_addr_log.size());
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        copy_active = 1'b0;
        #1;
        checks++;
        if ({read_request, write_request, copy_done, busy, read_address, read_len,
             write_address, write_len, write_data} !== '0) begin
            errors++;
            $display("FAIL rstmid_async_outputs: rreq=%b wreq=%b done=%b busy=%b, required all zero",
                     read_request, write_request, copy_done, busy);
        end
        tick(4);
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_no_done: copy_done pulses=%0d, required 0", done_cnt);
        end
        rst = 1'b1;
        tick(2);
        data_seed = $urandom;
        start_copy(32'h7400_0008, 32'h7500_0000, 32'd36);
        wait_done("rstmid_after");
        copy_active = 1'b0;
        checks++;
        if (done_cnt != 1 || qdiff(wr_data_log, exp_data) + qdiff(rd_addr_log, exp_rd_addr) +
            qdiff(wr_addr_log, exp_wr_addr) != 0) begin
            errors++;
            $display("FAIL rstmid_recover: done=%0d words=%0d, required done=1 and %0d matching words",
                     done_cnt, wr_data_log.size(), exp_data.size());
        end
        tick(2);
        $display("test_reset_mid: recovery copy words=%0d", wr_data_log.size());
    endtask

    task automatic test_random();
        logic [31:0] s, d, l;
        for (int it = 0; it < 6; it++) begin
            stall_pct = $urandom_range(0, 60);
            data_seed = $urandom;
            s = $urandom;
            d = $urandom;
            l = $urandom_range(0, 300);
            start_copy(s, d, l);
            wait_done("rand");
            copy_active = 1'b0;
            checks++;
            if (done_cnt != 1 || qdiff(rd_addr_log, exp_rd_addr) + qdiff(rd_len_log, exp_rd_len) +
                qdiff(wr_addr_log, exp_wr_addr) + qdiff(wr_len_log, exp_wr_len) != 0) begin
                errors++;
                $display("FAIL rand_bursts: it=%0d src=%h len=%0d done=%0d rd=%0d wr=%0d, required %0d bursts",
                         it, s, l, done_cnt, rd_addr_log.size(), wr_addr_log.size(), exp_rd_addr.size());
            end
            checks++;
            if (qdiff(wr_data_log, exp_data) != 0 ||
                (busy_err + rd_unstable + rd_drop_err + wr_unstable + wr_drop_err) != 0) begin
                errors++;
                $display("FAIL rand_data: it=%0d diffs=%0d protocol errs=%0d, required 0 and 0",
                         it, qdiff(wr_data_log, exp_data),
                         busy_err + rd_unstable + rd_drop_err + wr_unstable + wr_drop_err);
            end
            tick(2);
            $display("test_random it=%0d src=%h dst=%h len=%0d stall=%0d words=%0d",
                     it, s, d, l, stall_pct, wr_data_log.size());
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_single_word();
        test_multi_burst();
        test_rounding();
        test_zero_len();
        test_stall_restart();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
